// File: rtl/inv_pkg.sv
// Shared encodings and default sizing for the modular-inverse requester and its engine model.
package inv_pkg;

    localparam int INV_N       = 448;
    localparam int INV_TIMEOUT = 8191;
    localparam int INV_TW      = 13;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_ACK  = 3'd3,
        S_OUT  = 3'd4
    } inv_state_e;

endpackage

// File: rtl/inv_watchdog.sv
// Saturating cycle counter: hit pulses on the cycle the count reaches TIMEOUT,
// expired stays high while the count sits at TIMEOUT.
module inv_watchdog
    import inv_pkg::*;
#(
    parameter int TIMEOUT = INV_TIMEOUT,
    parameter int TW      = INV_TW
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit,
    output logic expired
);

    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIMIT);
    assign hit     = en && (cnt == LIMIT - 1'b1);

endmodule

// File: rtl/inv_requester.sv
// Initiator-side controller for the modular-inverse engine: range-checks one operand,
// issues a single request, returns the result downstream, and flags timeouts/protocol faults.
module inv_requester
    import inv_pkg::*;
#(
    parameter int N       = INV_N,
    parameter int TIMEOUT = INV_TIMEOUT,
    parameter int TW      = INV_TW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_x,
    input  logic [N-1:0] in_m,
    input  logic         in_real,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_r,
    output logic         out_err,
    output logic [N-1:0] inv_X,
    output logic [N-1:0] inv_M,
    output logic         inv_real_inverse,
    output logic         inv_req_valid,
    input  logic         inv_req_ready,
    input  logic         inv_req_busy,
    input  logic         inv_res_valid,
    output logic         inv_res_ready,
    input  logic [N-1:0] inv_R,
    input  logic         err_clr,
    output logic         err_timeout,
    output logic         err_proto
);

    inv_state_e state;
    logic       accept, bad_op;
    logic       wd_en, wd_hit, wd_expired;
    logic       busy_gap, idle_seen, proto_set;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign bad_op   = (in_x == '0) || (in_x >= in_m);
    assign wd_en    = (state == S_REQ) || (state == S_WAIT);

    inv_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (wd_en),
        .hit     (wd_hit),
        .expired (wd_expired)
    );

    // Engine idle while we still wait for its result: tolerated for one cycle only.
    assign busy_gap  = (state == S_WAIT) && !inv_req_busy && !inv_res_valid;
    assign proto_set = (inv_res_valid && (state == S_IDLE || state == S_REQ))
                    || (inv_req_ready && state != S_REQ)
                    || (busy_gap && idle_seen);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= S_IDLE;
            out_valid        <= 1'b0;
            out_err          <= 1'b0;
            out_r            <= '0;
            inv_req_valid    <= 1'b0;
            inv_res_ready    <= 1'b0;
            inv_X            <= '0;
            inv_M            <= '0;
            inv_real_inverse <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    // Engine samples M and real_inverse late, so these hold until the next accept.
                    inv_X            <= in_x;
                    inv_M            <= in_m;
                    inv_real_inverse <= in_real;
                    if (bad_op) begin
                        out_r     <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        inv_req_valid <= 1'b1;
                        state         <= S_REQ;
                    end
                end
                S_REQ: if (inv_req_ready) begin
                    inv_req_valid <= 1'b0;
                    state         <= S_WAIT;
                end
                S_WAIT: if (inv_res_valid) begin
                    out_r         <= inv_R;
                    out_err       <= 1'b0;
                    inv_res_ready <= 1'b1;
                    state         <= S_ACK;
                end
                S_ACK: begin
                    inv_res_ready <= 1'b0;
                    out_valid     <= 1'b1;
                    state         <= S_OUT;
                end
                S_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The reach event beats err_clr; a lingering expiry re-asserts the flag one cycle after a clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
            idle_seen   <= 1'b0;
        end else begin
            idle_seen   <= busy_gap;
            err_proto   <= proto_set || (err_proto && !err_clr);
            err_timeout <= wd_hit || (!err_clr && (err_timeout || (wd_expired && wd_en)));
        end
    end

endmodule

// File: tb/tb_inv_requester.sv
// Scoreboard bench for inv_requester with a behavioural inverse engine on the far side.
module tb_inv_requester;

    localparam int N       = 8;
    localparam int TIMEOUT = 16;
    localparam int TW      = 5;
    localparam int ENG_LAT = 6;

    typedef struct {
        logic [N-1:0] r;
        logic         e;
    } exp_t;

    logic         clk, rst;
    logic         in_valid, in_ready, in_real;
    logic [N-1:0] in_x, in_m;
    logic         out_valid, out_ready, out_err;
    logic [N-1:0] out_r;
    logic [N-1:0] inv_X, inv_M, inv_R;
    logic         inv_real_inverse, inv_req_valid, inv_req_ready, inv_req_busy;
    logic         inv_res_valid, inv_res_ready;
    logic         err_clr, err_timeout, err_proto;

    logic         eng_busy, eng_rv, hang;
    logic [N-1:0] eng_R;
    int           eng_cnt;
    logic         inj_res_valid, inj_req_ready, inj_busy_low;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0, n_fail = 0, n_done = 0;

    inv_requester #(.N(N), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_x             (in_x),
        .in_m             (in_m),
        .in_real          (in_real),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_r            (out_r),
        .out_err          (out_err),
        .inv_X            (inv_X),
        .inv_M            (inv_M),
        .inv_real_inverse (inv_real_inverse),
        .inv_req_valid    (inv_req_valid),
        .inv_req_ready    (inv_req_ready),
        .inv_req_busy     (inv_req_busy),
        .inv_res_valid    (inv_res_valid),
        .inv_res_ready    (inv_res_ready),
        .inv_R            (inv_R),
        .err_clr          (err_clr),
        .err_timeout      (err_timeout),
        .err_proto        (err_proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Engine model: brute-force inverse, optional Montgomery scaling by 2^N.
    function automatic logic [N-1:0] eng_inv(input logic [N-1:0] x, input logic [N-1:0] m,
                                             input logic rl);
        int y = 0;
        for (int i = 1; i < int'(m); i++)
            if ((int'(x) * i) % int'(m) == 1) y = i;
        if (!rl) y = (y * (1 << N)) % int'(m);
        return N'(y);
    endfunction

    assign inv_req_ready = (inv_req_valid && !eng_busy) || inj_req_ready;
    assign inv_req_busy  = eng_busy && !inj_busy_low;
    assign inv_res_valid = eng_rv || inj_res_valid;
    assign inv_R         = eng_R;

    always @(posedge clk) begin
        if (!rst) begin
            eng_busy <= 1'b0;
            eng_rv   <= 1'b0;
            eng_cnt  <= 0;
            eng_R    <= '0;
        end else begin
            if (inv_req_valid && inv_req_ready) begin
                eng_busy <= 1'b1;
                eng_cnt  <= ENG_LAT;
            end else if (eng_busy && !eng_rv) begin
                if (eng_cnt == 0) begin
                    if (!hang) begin
                        eng_rv <= 1'b1;
                        eng_R  <= eng_inv(inv_X, inv_M, inv_real_inverse);
                    end
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
            if (eng_rv && inv_res_ready) begin
                eng_rv   <= 1'b0;
                eng_busy <= 1'b0;
            end
        end
    end

    // Pop on the downstream handshake that the next rising edge completes.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", out_valid, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_r", out_r, mon_e.r);
                chk("out_err", out_err, mon_e.e);
                n_done++;
            end
        end
    end

    task automatic rst_chk(input string tag);
        chk({tag, "_ctl"}, {out_valid, out_err, inv_req_valid, inv_res_ready,
                            err_timeout, err_proto, in_ready}, 7'b0000001);
        chk({tag, "_data"}, {out_r, inv_X, inv_M}, '0);
    endtask

    task automatic rst_pulse(input string tag);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_chk(tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic [N-1:0] x, input logic [N-1:0] m, input logic rl,
                        input logic [N-1:0] er, input logic ee);
        exp_t e;
        int   t_res, t_out, n_req, n_rack, base;
        bit   ok;
        e.r = er; e.e = ee;
        sb.push_back(e);
        base = n_done; t_res = -1; t_out = -1; n_req = 0; n_rack = 0; ok = 0;
        in_valid = 1'b1; in_x = x; in_m = m; in_real = rl;
        @(negedge clk);
        chk("in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int t = 1; t <= 100 && !ok; t++) begin
            @(negedge clk);
            if (t == 1) begin
                chk("req_lat", inv_req_valid, !ee);
                chk("rej_lat", out_valid, ee);
                chk("inv_XM", {inv_X, inv_M, inv_real_inverse}, {x, m, rl});
            end
            if (inv_req_valid && inv_req_ready) n_req++;
            if (inv_res_ready) n_rack++;
            if (inv_res_valid && t_res < 0) t_res = t;
            if (out_valid && t_out < 0) t_out = t;
            if (n_done != base) ok = 1;
        end
        chk("xact_done", ok, 1'b1);
        chk("req_cnt", n_req, ee ? 0 : 1);
        chk("res_ack_cnt", n_rack, ee ? 0 : 1);
        if (!ee) chk("res_to_out", t_out - t_res, 2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   base;
        bit   ok;
        rst = 1'b0; in_valid = 1'b0; in_x = '0; in_m = '0; in_real = 1'b0;
        out_ready = 1'b1; err_clr = 1'b0; hang = 1'b0;
        inj_res_valid = 1'b0; inj_req_ready = 1'b0; inj_busy_low = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_chk("por");
        rst = 1'b1;
        @(posedge clk);
        #1;

        xact(8'd3,  8'd13,  1'b1, 8'd9,   1'b0);
        xact(8'd3,  8'd13,  1'b0, 8'd3,   1'b0);
        xact(8'd0,  8'd13,  1'b1, 8'd0,   1'b1);
        xact(8'd13, 8'd13,  1'b1, 8'd0,   1'b1);
        xact(8'd20, 8'd13,  1'b0, 8'd0,   1'b1);
        xact(8'd12, 8'd13,  1'b0, 8'd4,   1'b0);
        xact(8'd2,  8'd255, 1'b1, 8'd128, 1'b0);
        chk("err_clean", {err_timeout, err_proto}, 2'b00);

        // Downstream stall with a competing operand held on the input.
        base = n_done;
        out_ready = 1'b0;
        e.r = 8'd8; e.e = 1'b0;
        sb.push_back(e);
        in_valid = 1'b1; in_x = 8'd7; in_m = 8'd11; in_real = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = out_valid;
        end
        chk("stall_out", ok, 1'b1);
        e.r = 8'd12; e.e = 1'b0;
        sb.push_back(e);
        in_valid = 1'b1; in_x = 8'd12; in_m = 8'd13;
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {out_valid, out_err, out_r, in_ready}, {1'b1, 1'b0, 8'd8, 1'b0});
            @(negedge clk);
        end
        chk("stall_X", inv_X, 8'd7);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("resume_rdy", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("resume_req", {inv_req_valid, inv_X}, {1'b1, 8'd12});
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = (n_done == base + 2);
        end
        chk("resume_done", ok, 1'b1);
        @(posedge clk);
        #1;

        // Watchdog: engine never answers.
        hang = 1'b1;
        in_valid = 1'b1; in_x = 8'd3; in_m = 8'd13; in_real = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 15) chk("wd_early", err_timeout, 1'b0);
            if (k == 16) chk("wd_fire", err_timeout, 1'b1);
        end
        err_clr = 1'b1;
        @(negedge clk);
        chk("wd_clr", err_timeout, 1'b0);
        err_clr = 1'b0;
        @(negedge clk);
        chk("wd_refire", err_timeout, 1'b1);
        chk("wd_no_proto", err_proto, 1'b0);
        @(posedge clk);
        #1;
        rst_pulse("rst_hang");
        hang = 1'b0;

        // Reset while the engine is mid-computation.
        in_valid = 1'b1; in_x = 8'd3; in_m = 8'd13; in_real = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_pulse("rst_mid");
        xact(8'd5, 8'd13, 1'b1, 8'd8, 1'b0);

        // Protocol violations.
        inj_res_valid = 1'b1;
        @(posedge clk);
        #1 inj_res_valid = 1'b0;
        @(negedge clk);
        chk("proto_res_idle", err_proto, 1'b1);
        @(negedge clk);
        chk("proto_sticky", err_proto, 1'b1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("proto_clr", err_proto, 1'b0);
        @(posedge clk);
        #1 inj_req_ready = 1'b1;
        @(posedge clk);
        #1 inj_req_ready = 1'b0;
        @(negedge clk);
        chk("proto_rdy_idle", err_proto, 1'b1);
        @(posedge clk);
        #1 begin err_clr = 1'b1; inj_res_valid = 1'b1; end
        @(posedge clk);
        #1 begin err_clr = 1'b0; inj_res_valid = 1'b0; end
        @(negedge clk);
        chk("proto_set_wins", err_proto, 1'b1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("proto_clr2", err_proto, 1'b0);

        hang = 1'b1;
        @(posedge clk);
        #1 begin in_valid = 1'b1; in_x = 8'd3; in_m = 8'd13; end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 inj_busy_low = 1'b1;
        @(posedge clk);
        #1 inj_busy_low = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("proto_gap1", err_proto, 1'b0);
        inj_busy_low = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 inj_busy_low = 1'b0;
        @(negedge clk);
        chk("proto_gap2", err_proto, 1'b1);
        @(posedge clk);
        #1;
        rst_pulse("rst_end");
        hang = 1'b0;
        xact(8'd12, 8'd13, 1'b0, 8'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
